// File: rtl/sr_latch.sv
// Clocked set/reset latch holding the magnetron enable bit, with an optional
// input synchronizer and one-cycle pulses on each change of the latched state.
module sr_latch #(
  parameter int unsigned SYNC_STAGES    = 2,    // legal range 0..4
  parameter bit          RESET_DOMINANT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_n,
  output logic set_evt,
  output logic clr_evt
);

  logic s_sync;
  logic r_sync;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign s_sync = s;
      assign r_sync = r;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] s_pipe_q;
      logic [SYNC_STAGES-1:0] r_pipe_q;

      // NOTE: synchronizer flops are cleared on reset so stale requests captured
      // before reset cannot re-enable the magnetron after it is released.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s_pipe_q <= '0;
          r_pipe_q <= '0;
        end else begin
          s_pipe_q[0] <= s;
          r_pipe_q[0] <= r;
          for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            s_pipe_q[i] <= s_pipe_q[i-1];
            r_pipe_q[i] <= r_pipe_q[i-1];
          end
        end
      end

      assign s_sync = s_pipe_q[SYNC_STAGES-1];
      assign r_sync = r_pipe_q[SYNC_STAGES-1];
    end
  endgenerate

  logic q_q;
  logic q_d;
  logic q_n_q;
  logic set_evt_q;
  logic clr_evt_q;

  // NOTE: q_d is assigned on every path (full case plus default), so no latch
  // is inferred for the next-state value.
  always_comb begin
    q_d = q_q;
    unique case ({s_sync, r_sync})
      2'b00:   q_d = q_q;
      2'b10:   q_d = 1'b1;
      2'b01:   q_d = 1'b0;
      default: q_d = ~RESET_DOMINANT;
    endcase
  end

  // NOTE: non-blocking assignments keep every register updating from the
  // values present before the edge, so q and the event pulses stay aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q       <= 1'b0;
      q_n_q     <= 1'b1;
      set_evt_q <= 1'b0;
      clr_evt_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      q_n_q     <= ~q_d;
      set_evt_q <= ~q_q & q_d;
      clr_evt_q <= q_q & ~q_d;
    end
  end

  assign q       = q_q;
  assign q_n     = q_n_q;
  assign set_evt = set_evt_q;
  assign clr_evt = clr_evt_q;

endmodule

// File: tb/tb_sr_latch.sv
// Self-checking bench for sr_latch: three instances (default, bypass, set-dominant)
// share one stimulus stream; a per-edge model feeds a scoreboard queue.
module tb_sr_latch;

  localparam int N_DUT = 3;
  localparam int STAGES [N_DUT] = '{2, 0, 2};
  localparam bit DOM    [N_DUT] = '{1'b1, 1'b1, 1'b0};

  logic clk;
  logic rst_n;
  logic s;
  logic r;
  logic [N_DUT-1:0] q_o;
  logic [N_DUT-1:0] qn_o;
  logic [N_DUT-1:0] se_o;
  logic [N_DUT-1:0] ce_o;

  sr_latch #(.SYNC_STAGES(2), .RESET_DOMINANT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r),
    .q(q_o[0]), .q_n(qn_o[0]), .set_evt(se_o[0]), .clr_evt(ce_o[0])
  );

  sr_latch #(.SYNC_STAGES(0), .RESET_DOMINANT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r),
    .q(q_o[1]), .q_n(qn_o[1]), .set_evt(se_o[1]), .clr_evt(ce_o[1])
  );

  sr_latch #(.SYNC_STAGES(2), .RESET_DOMINANT(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r),
    .q(q_o[2]), .q_n(qn_o[2]), .set_evt(se_o[2]), .clr_evt(ce_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  string cur_test = "init";

  logic [4*N_DUT-1:0] sb [$];
  bit hist_s [$];
  bit hist_r [$];
  int since_rst = 0;
  bit mq [N_DUT];
  int set_cnt [N_DUT];
  int clr_cnt [N_DUT];

  task automatic clear_counts();
    for (int d = 0; d < N_DUT; d++) begin
      set_cnt[d] = 0;
      clr_cnt[d] = 0;
    end
  endtask

  // Drive one cycle of inputs, push the model's expectation for the coming edge,
  // then pop it and compare once the DUTs have updated.
  task automatic tick(input bit s_v, input bit r_v, input bit rst_v);
    logic [4*N_DUT-1:0] exp_w;
    logic [3:0] obs;
    bit se, re, nq;
    s = s_v;
    r = r_v;
    rst_n = rst_v;
    hist_s.push_front(s_v);
    hist_r.push_front(r_v);
    if (hist_s.size() > 8) begin
      void'(hist_s.pop_back());
      void'(hist_r.pop_back());
    end
    exp_w = '0;
    for (int d = 0; d < N_DUT; d++) begin
      if (!rst_v) begin
        nq = 1'b0;
      end else begin
        se = 1'b0;
        re = 1'b0;
        // A request reaches the latch only if it was driven STAGES edges ago and
        // no reset edge has flushed the synchronizer since.
        if (since_rst >= STAGES[d]) begin
          se = hist_s[STAGES[d]];
          re = hist_r[STAGES[d]];
        end
        if (se && re)  nq = !DOM[d];
        else if (se)   nq = 1'b1;
        else if (re)   nq = 1'b0;
        else           nq = mq[d];
      end
      exp_w[4*d +: 4] = {nq, !nq, rst_v && !mq[d] && nq, rst_v && mq[d] && !nq};
      mq[d] = nq;
    end
    since_rst = rst_v ? since_rst + 1 : 0;
    sb.push_back(exp_w);

    @(posedge clk);
    #1;
    cyc++;
    exp_w = sb.pop_front();
    for (int d = 0; d < N_DUT; d++) begin
      obs = {q_o[d], qn_o[d], se_o[d], ce_o[d]};
      checks++;
      if (obs !== exp_w[4*d +: 4]) begin
        errors++;
        $display("FAIL sb_%s dut%0d cycle %0d: q/qn/set/clr got %b expected %b",
                 cur_test, d, cyc, obs, exp_w[4*d +: 4]);
      end
      checks++;
      if (qn_o[d] !== ~q_o[d]) begin
        errors++;
        $display("FAIL qn_inverse_%s dut%0d cycle %0d: q_n got %b expected %b",
                 cur_test, d, cyc, qn_o[d], ~q_o[d]);
      end
      if (se_o[d] === 1'b1) set_cnt[d]++;
      if (ce_o[d] === 1'b1) clr_cnt[d]++;
    end
  endtask

  task automatic test_reset();
    int first_hi [N_DUT];
    cur_test = "reset";
    repeat (2) tick(1'b1, 1'b0, 1'b0);
    for (int d = 0; d < N_DUT; d++) begin
      checks++;
      if ({q_o[d], qn_o[d], se_o[d], ce_o[d]} !== 4'b0100) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %b expected 0100", d,
                 {q_o[d], qn_o[d], se_o[d], ce_o[d]});
      end
      first_hi[d] = -1;
    end
    clear_counts();
    for (int k = 1; k <= 4; k++) begin
      tick(1'b1, 1'b0, 1'b1);
      for (int d = 0; d < N_DUT; d++)
        if (first_hi[d] < 0 && q_o[d] === 1'b1) first_hi[d] = k;
    end
    for (int d = 0; d < N_DUT; d++) begin
      checks++;
      if (first_hi[d] != STAGES[d] + 1) begin
        errors++;
        $display("FAIL reset_release_latency dut%0d: got %0d edges expected %0d",
                 d, first_hi[d], STAGES[d] + 1);
      end
      checks++;
      if (set_cnt[d] != 1) begin
        errors++;
        $display("FAIL reset_release_set_evt dut%0d: got %0d pulses expected 1", d, set_cnt[d]);
      end
    end
  endtask

  task automatic test_set_hold();
    cur_test = "set_hold";
    repeat (6) tick(1'b0, 1'b1, 1'b1);
    clear_counts();
    repeat (10) tick(1'b1, 1'b0, 1'b1);
    for (int d = 0; d < N_DUT; d++) begin
      checks++;
      if (q_o[d] !== 1'b1 || set_cnt[d] != 1 || clr_cnt[d] != 0) begin
        errors++;
        $display("FAIL set_once dut%0d: q=%b set=%0d clr=%0d expected q=1 set=1 clr=0",
                 d, q_o[d], set_cnt[d], clr_cnt[d]);
      end
    end
    clear_counts();
    repeat (10) tick(1'b0, 1'b0, 1'b1);
    for (int d = 0; d < N_DUT; d++) begin
      checks++;
      if (q_o[d] !== 1'b1 || set_cnt[d] + clr_cnt[d] != 0) begin
        errors++;
        $display("FAIL hold dut%0d: q=%b pulses=%0d expected q=1 pulses=0",
                 d, q_o[d], set_cnt[d] + clr_cnt[d]);
      end
    end
  endtask

  task automatic test_clear();
    cur_test = "clear";
    clear_counts();
    repeat (10) tick(1'b0, 1'b1, 1'b1);
    for (int d = 0; d < N_DUT; d++) begin
      checks++;
      if (q_o[d] !== 1'b0 || qn_o[d] !== 1'b1 || clr_cnt[d] != 1 || set_cnt[d] != 0) begin
        errors++;
        $display("FAIL clear_once dut%0d: q=%b qn=%b clr=%0d set=%0d expected 0 1 1 0",
                 d, q_o[d], qn_o[d], clr_cnt[d], set_cnt[d]);
      end
    end
    clear_counts();
    repeat (10) tick(1'b0, 1'b1, 1'b1);
    for (int d = 0; d < N_DUT; d++) begin
      checks++;
      if (q_o[d] !== 1'b0 || clr_cnt[d] != 0) begin
        errors++;
        $display("FAIL clear_repeat dut%0d: q=%b clr=%0d expected q=0 clr=0", d, q_o[d], clr_cnt[d]);
      end
    end
  endtask

  task automatic test_conflict();
    cur_test = "conflict";
    repeat (10) tick(1'b1, 1'b0, 1'b1);
    clear_counts();
    repeat (10) tick(1'b1, 1'b1, 1'b1);
    for (int d = 0; d < N_DUT; d++) begin
      checks++;
      if (q_o[d] !== !DOM[d] || clr_cnt[d] != (DOM[d] ? 1 : 0)) begin
        errors++;
        $display("FAIL conflict_from_set dut%0d: q=%b clr=%0d expected q=%b clr=%0d",
                 d, q_o[d], clr_cnt[d], !DOM[d], DOM[d] ? 1 : 0);
      end
    end
    repeat (10) tick(1'b0, 1'b1, 1'b1);
    clear_counts();
    repeat (10) tick(1'b1, 1'b1, 1'b1);
    for (int d = 0; d < N_DUT; d++) begin
      checks++;
      if (q_o[d] !== !DOM[d] || set_cnt[d] != (DOM[d] ? 0 : 1)) begin
        errors++;
        $display("FAIL conflict_from_clear dut%0d: q=%b set=%0d expected q=%b set=%0d",
                 d, q_o[d], set_cnt[d], !DOM[d], DOM[d] ? 0 : 1);
      end
    end
  endtask

  task automatic test_cyclic();
    bit step_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit step_r [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit exp_rd [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit exp_sd [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit want;
    cur_test = "cyclic";
    for (int round = 0; round < 3; round++) begin
      for (int st = 0; st < 4; st++) begin
        repeat (10) tick(step_s[st], step_r[st], 1'b1);
        for (int d = 0; d < N_DUT; d++) begin
          want = DOM[d] ? exp_rd[st] : exp_sd[st];
          checks++;
          if (q_o[d] !== want) begin
            errors++;
            $display("FAIL cyclic_r%0d_s%0d dut%0d: q got %b expected %b", round, st, d, q_o[d], want);
          end
        end
      end
    end
  endtask

  task automatic test_bypass();
    cur_test = "bypass";
    repeat (6) tick(1'b0, 1'b1, 1'b1);
    repeat (4) tick(1'b0, 1'b0, 1'b1);
    clear_counts();
    tick(1'b1, 1'b0, 1'b1);
    checks++;
    if (q_o[1] !== 1'b1 || q_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL bypass_edge1: q_bypass=%b q_sync=%b expected 1 0", q_o[1], q_o[0]);
    end
    tick(1'b0, 1'b0, 1'b1);
    checks++;
    if (q_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL sync_edge2: q got %b expected 0", q_o[0]);
    end
    tick(1'b0, 1'b0, 1'b1);
    checks++;
    if (q_o[0] !== 1'b1 || q_o[2] !== 1'b1 || q_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL sync_edge3: q got %b%b%b expected 111", q_o[2], q_o[1], q_o[0]);
    end
    for (int d = 0; d < N_DUT; d++) begin
      checks++;
      if (set_cnt[d] != 1) begin
        errors++;
        $display("FAIL pulse_set_evt dut%0d: got %0d pulses expected 1", d, set_cnt[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    cur_test = "back_to_back";
    clear_counts();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) tick(1'b0, 1'b1, 1'b1);
      else            tick(1'b1, 1'b0, 1'b1);
    end
    repeat (4) tick(1'b0, 1'b0, 1'b1);
    for (int d = 0; d < N_DUT; d++) begin
      checks++;
      if (set_cnt[d] != 4 || clr_cnt[d] != 4 || q_o[d] !== 1'b1) begin
        errors++;
        $display("FAIL toggle dut%0d: set=%0d clr=%0d q=%b expected 4 4 1",
                 d, set_cnt[d], clr_cnt[d], q_o[d]);
      end
    end
  endtask

  task automatic test_mid_reset();
    cur_test = "mid_reset";
    repeat (10) tick(1'b1, 1'b0, 1'b1);
    clear_counts();
    tick(1'b1, 1'b0, 1'b0);
    for (int d = 0; d < N_DUT; d++) begin
      checks++;
      if ({q_o[d], qn_o[d], se_o[d], ce_o[d]} !== 4'b0100) begin
        errors++;
        $display("FAIL mid_reset_state dut%0d: got %b expected 0100", d,
                 {q_o[d], qn_o[d], se_o[d], ce_o[d]});
      end
    end
    repeat (5) tick(1'b1, 1'b0, 1'b1);
    for (int d = 0; d < N_DUT; d++) begin
      checks++;
      if (q_o[d] !== 1'b1 || set_cnt[d] != 1 || clr_cnt[d] != 0) begin
        errors++;
        $display("FAIL mid_reset_recover dut%0d: q=%b set=%0d clr=%0d expected 1 1 0",
                 d, q_o[d], set_cnt[d], clr_cnt[d]);
      end
    end
  endtask

  initial begin
    s = 1'b0;
    r = 1'b0;
    rst_n = 1'b0;
    for (int d = 0; d < N_DUT; d++) mq[d] = 1'b0;
    clear_counts();
    test_reset();
    test_set_hold();
    test_clear();
    test_conflict();
    test_cyclic();
    test_bypass();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
